// File: rtl/triangle_job_arbiter.sv
// Round-robin arbiter sharing one triangle point-enumeration engine between N_REQ job sources.
// Optional watchdog abort of stuck jobs is enabled by defining TRI_ARB_WATCHDOG_EN.
module triangle_job_arbiter #(
    parameter int N_REQ     = 4,
    parameter int CW        = 3,
    parameter int WD_CYCLES = 255,
    localparam int IDW      = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int VW       = 6 * CW,
    localparam int NW       = 2 * CW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*VW-1:0]   req_vtx,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  eng_nt,
    output logic [CW-1:0]         eng_xi,
    output logic [CW-1:0]         eng_yi,
    input  logic                  eng_busy,
    input  logic                  eng_po,
    input  logic [CW-1:0]         eng_xo,
    input  logic [CW-1:0]         eng_yo,
    output logic                  out_valid,
    output logic [CW-1:0]         out_x,
    output logic [CW-1:0]         out_y,
    output logic [IDW-1:0]        out_id,
    output logic                  job_done,
    output logic [NW-1:0]         done_cnt,
    output logic                  done_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FEED0     = 3'd1;
    localparam logic [2:0] S_FEED1     = 3'd2;
    localparam logic [2:0] S_FEED2     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    if (N_REQ < 2 || N_REQ > 8 || WD_CYCLES < 1) begin : g_bad_params
        $error("triangle_job_arbiter: N_REQ must be 2..8 and WD_CYCLES at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [VW-1:0]     vtx_q, vtx_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic              eng_nt_q, eng_nt_d;
    logic [CW-1:0]     eng_xi_q, eng_xi_d;
    logic [CW-1:0]     eng_yi_q, eng_yi_d;
    logic              out_valid_q, out_valid_d;
    logic [CW-1:0]     out_x_q, out_x_d;
    logic [CW-1:0]     out_y_q, out_y_d;
    logic [IDW-1:0]    out_id_q, out_id_d;
    logic              job_done_q, job_done_d;
    logic [NW-1:0]     done_cnt_q, done_cnt_d;
    logic              done_err_q, done_err_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    scan_idx;
    logic [VW-1:0]     sel_vtx;
    logic              point_hit;
    logic [NW-1:0]     cnt_inc;
    logic              wd_hit;

`ifdef TRI_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;

    // Counts cycles spent waiting on the engine; fires on the last allowed cycle.
    always_comb begin
        wd_d   = wd_q;
        wd_hit = 1'b0;
        if (state_q == S_FEED2) begin
            wd_d = '0;
        end else if (state_q == S_WAIT_BUSY || state_q == S_RUN) begin
            if (wd_q == WDW'(WD_CYCLES - 1)) begin
                wd_hit = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Rotating-priority scan starting at ptr, plus the winner's vertex bundle.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        sel_vtx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = IDW'((int'(ptr_q) + i) % N_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == grant_id) begin
                sel_vtx = req_vtx[k*VW +: VW];
            end
        end
    end

    assign point_hit = eng_po && (state_q == S_WAIT_BUSY || state_q == S_RUN);
    assign cnt_inc   = !point_hit ? cnt_q : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    // Next-state and next-output logic; every output is the registered image of *_d.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        vtx_d       = vtx_q;
        cnt_d       = cnt_inc;
        req_ready_d = '0;
        eng_nt_d    = 1'b0;
        eng_xi_d    = '0;
        eng_yi_d    = '0;
        out_valid_d = point_hit;
        out_x_d     = point_hit ? eng_xo : '0;
        out_y_d     = point_hit ? eng_yo : '0;
        job_done_d  = 1'b0;
        done_cnt_d  = '0;
        done_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_found && !eng_busy) begin
                    state_d     = S_FEED0;
                    id_d        = grant_id;
                    vtx_d       = sel_vtx;
                    req_ready_d = N_REQ'(1) << grant_id;
                    eng_nt_d    = 1'b1;
                    eng_xi_d    = sel_vtx[0 +: CW];
                    eng_yi_d    = sel_vtx[CW +: CW];
                end
            end
            S_FEED0: begin
                state_d  = S_FEED1;
                eng_xi_d = vtx_q[2*CW +: CW];
                eng_yi_d = vtx_q[3*CW +: CW];
            end
            S_FEED1: begin
                state_d  = S_FEED2;
                eng_xi_d = vtx_q[4*CW +: CW];
                eng_yi_d = vtx_q[5*CW +: CW];
            end
            S_FEED2: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_RUN: begin
                if (wd_hit || (state_q == S_RUN && !eng_busy)) begin
                    state_d    = S_DONE;
                    job_done_d = 1'b1;
                    done_cnt_d = cnt_inc;
                    done_err_d = wd_hit;
                end else if (state_q == S_WAIT_BUSY && eng_busy) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_id_d = (state_d == S_IDLE) ? '0 : id_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            vtx_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            eng_nt_q    <= 1'b0;
            eng_xi_q    <= '0;
            eng_yi_q    <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_id_q    <= '0;
            job_done_q  <= 1'b0;
            done_cnt_q  <= '0;
            done_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            vtx_q       <= vtx_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            eng_nt_q    <= eng_nt_d;
            eng_xi_q    <= eng_xi_d;
            eng_yi_q    <= eng_yi_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_id_q    <= out_id_d;
            job_done_q  <= job_done_d;
            done_cnt_q  <= done_cnt_d;
            done_err_q  <= done_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign eng_nt    = eng_nt_q;
    assign eng_xi    = eng_xi_q;
    assign eng_yi    = eng_yi_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_id    = out_id_q;
    assign job_done  = job_done_q;
    assign done_cnt  = done_cnt_q;
    assign done_err  = done_err_q;

endmodule

// File: doc/triangle_job_arbiter.md
Name: triangle_job_arbiter

Overview:
- Shares one triangle point-enumeration engine between N_REQ requesters.
- Round-robin arbitration over pending jobs; each job is three vertices.
- Sequences the engine's nt/xi/yi loading protocol, then routes the engine's po/xo/yo point stream back, tagged with the owner's id.
- Sits between job sources and the single triangle engine instance.

Parameters:
- N_REQ, 4, number of requesters (2..8); IDW = max(1, clog2(N_REQ)).
- CW, 3, coordinate width.
- WD_CYCLES, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  N_REQ  per-requester job pending; held until matching req_ready.
- req_vtx  in  N_REQ*6*CW  requester k at [k*6*CW +: 6*CW]; vertex v x at [v*2*CW +: CW], y at [v*2*CW+CW +: CW].
- req_ready  out  N_REQ  one-hot, 1-cycle pulse: job accepted, vertices captured.
- eng_nt  out  1  engine new-triangle strobe.
- eng_xi, eng_yi  out  CW each  engine vertex inputs.
- eng_busy  in  1  engine busy.
- eng_po  in  1  engine point valid.
- eng_xo, eng_yo  in  CW each  engine point coordinates.
- out_valid  out  1  point valid to owner.
- out_x, out_y  out  CW each  point coordinates.
- out_id  out  IDW  owner of the current point/job.
- job_done  out  1  1-cycle pulse at job end.
- done_cnt  out  2*CW+1  points forwarded for the finished job; valid with job_done.
- done_err  out  1  job aborted; valid with job_done.

Behaviour:
- All outputs registered.
- Reset (asserted) values: every output 0; state IDLE; rr pointer 0; capture registers 0.
- States: IDLE, FEED0, FEED1, FEED2, WAIT_BUSY, RUN, DONE.
- IDLE:
  - If any req_valid and eng_busy==0: pick the first set req_valid scanning from ptr upward, wrapping. Capture that requester's 3 vertices and its id, go to FEED0.
  - If eng_busy==1: no grant, stay in IDLE.
- FEED0:
  - req_ready[id]=1 this cycle only.
  - eng_nt=1, eng_xi/eng_yi = vertex 0.
- FEED1: eng_nt=0, vertex 1.
- FEED2: eng_nt=0, vertex 2.
- Leaving FEED2: eng_xi/eng_yi return to 0; next state WAIT_BUSY.
- WAIT_BUSY: stay until eng_busy==1, then RUN.
- RUN: when eng_busy==0, go to DONE.
- Point forwarding (WAIT_BUSY and RUN):
  - Each eng_po=1 cycle registers out_valid=1, out_x=eng_xo, out_y=eng_yo, out_id=owner one cycle later; increments the point counter.
  - A po coincident with busy falling is still forwarded.
  - po in any other state is ignored.
- DONE (one cycle):
  - job_done=1, done_cnt=counter, out_id=owner.
  - ptr <= (owner+1) mod N_REQ; counter cleared; go to IDLE.
  - The next grant is possible on the following cycle.
- Latency: valid-in-IDLE to eng_nt = 1 cycle; eng_po to out_valid = 1 cycle.
- Counter saturates at all-ones; no wrap.
- req_valid deasserted by a non-owner at any time: no effect.
- An owner dropping req_valid after capture does not abort the job.
- Reset mid-job: immediate return to IDLE. Engine receives no further strobes. The job is lost and no job_done is issued; the requester resubmits.

Optional Feature:
- Macro TRI_ARB_WATCHDOG_EN.
- Defined:
  - Cycle counter runs in WAIT_BUSY and RUN.
  - Reaching WD_CYCLES forces DONE with done_err=1, and ptr advances normally.
  - In the next IDLE, grants remain blocked until eng_busy==0.
- Undefined: no counter; waits indefinitely; done_err tied 0.

Test Plan:
- Single job: req_valid=0001, vertices (1,0),(1,4),(5,0); engine model emits 15 points. Expect eng_nt high 1 cycle with (1,0), then (1,4), (5,0); 15 out_valid with out_id=0; job_done with done_cnt=15; req_ready=0001 exactly once.
- Round-robin: req_valid=1111 held, ptr=0. Expect grant order 0,1,2,3,0; each next FEED0 follows the previous DONE by exactly one IDLE cycle.
- Engine busy at request: eng_busy=1 for 10 cycles while req_valid=0010. Expect no eng_nt until 1 cycle after busy falls.
- Boundary point: eng_po=1 in the same cycle eng_busy falls. Expect that point forwarded; done_cnt includes it; job_done on the next cycle.
- Reset mid-RUN: reset=0 after 3 points. Expect all outputs 0 asynchronously; no job_done; after release, ptr=0 and a new request is granted normally.
- With TRI_ARB_WATCHDOG_EN, WD_CYCLES=20: engine never raises busy. Expect job_done with done_err=1 exactly 20 cycles after entering WAIT_BUSY, done_cnt=0.
